// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common data bus arbiter: two result FIFOs, round-robin pop, registered broadcast
module cdb_arbiter #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic             alu_valid,
  input  logic [TAG_W-1:0] alu_tag,
  input  logic [31:0]      alu_value,
  output logic             alu_ready,
  input  logic             lsb_valid,
  input  logic [TAG_W-1:0] lsb_tag,
  input  logic [31:0]      lsb_value,
  output logic             lsb_ready,
  output logic             cdb_valid,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_value,
  output logic             cdb_src
);

  localparam int ENT_W = TAG_W + 32;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // Index 0 is the ALU path, index 1 the load-store buffer.
  logic [ENT_W-1:0] mem [2][DEPTH];
  logic [PTR_W-1:0] head [2];
  logic [PTR_W-1:0] tail [2];
  logic [PTR_W:0]   count [2];
  logic             last_grant;

  logic [1:0]       in_valid;
  logic [ENT_W-1:0] in_data [2];
  logic [1:0]       ready;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       nonempty;
  logic             grant;

  always_comb begin
    in_valid   = {lsb_valid, alu_valid};
    in_data[0] = {alu_tag, alu_value};
    in_data[1] = {lsb_tag, lsb_value};
    for (int i = 0; i < 2; i++) begin
      nonempty[i] = (count[i] != '0);
      ready[i]    = rdy_in && (count[i] != FULL_CNT);
      push[i]     = in_valid[i] && ready[i] && !clear_in;
    end
    // On a tie the requester that did not win last time is served.
    grant = (nonempty == 2'b11) ? ~last_grant : nonempty[1];
    pop   = 2'b00;
    if (rdy_in && !clear_in && (nonempty != 2'b00))
      pop[grant] = 1'b1;
  end

  assign alu_ready = ready[0];
  assign lsb_ready = ready[1];

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < 2; i++)
      if (push[i])
        mem[i][tail[i]] <= in_data[i];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 2; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
      last_grant <= 1'b1;
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_value  <= '0;
      cdb_src    <= 1'b0;
    end else if (rdy_in) begin
      if (clear_in) begin
        for (int i = 0; i < 2; i++) begin
          head[i]  <= '0;
          tail[i]  <= '0;
          count[i] <= '0;
        end
        cdb_valid <= 1'b0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (push[i])
            tail[i] <= tail[i] + 1'b1;
          if (pop[i])
            head[i] <= head[i] + 1'b1;
          count[i] <= count[i] + {{PTR_W{1'b0}}, push[i]} - {{PTR_W{1'b0}}, pop[i]};
        end
        cdb_valid <= |pop;
        // Payload holds its last value when nothing is granted.
        if (|pop) begin
          cdb_tag    <= mem[grant][head[grant]][ENT_W-1:32];
          cdb_value  <= mem[grant][head[grant]][31:0];
          cdb_src    <= grant;
          last_grant <= grant;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;
  localparam int TAG_W = 4;

  logic             clk_in = 1'b0;
  logic             rst_in, rdy_in, clear_in;
  logic             alu_valid, lsb_valid;
  logic [TAG_W-1:0] alu_tag, lsb_tag;
  logic [31:0]      alu_value, lsb_value;
  logic             alu_ready, lsb_ready;
  logic             cdb_valid, cdb_src;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;

  int checks = 0;
  int errors = 0;
  logic [TAG_W+32:0] exp_q[$];
  logic [TAG_W+32:0] exp_e;
  logic fresh = 1'b0;

  always #5 clk_in = ~clk_in;

  cdb_arbiter #(.TAG_W(TAG_W), .DEPTH(4), .PTR_W(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_value(alu_value), .alu_ready(alu_ready),
    .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_value(lsb_value), .lsb_ready(lsb_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_src(cdb_src)
  );

  // A broadcast is new only if the edge that produced it was not paused.
  always @(posedge clk_in) fresh <= rdy_in && !rst_in;

  always @(negedge clk_in) begin
    if (cdb_valid && fresh) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cdb_unexpected got src=%0d tag=%0d value=%h want no broadcast",
                 cdb_src, cdb_tag, cdb_value);
      end else begin
        exp_e = exp_q.pop_front();
        if ({cdb_src, cdb_tag, cdb_value} !== exp_e) begin
          errors++;
          $display("FAIL cdb_order got src=%0d tag=%0d value=%h want src=%0d tag=%0d value=%h",
                   cdb_src, cdb_tag, cdb_value, exp_e[TAG_W+32], exp_e[TAG_W+31:32], exp_e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  function automatic logic [TAG_W+32:0] ent(input logic src, input logic [TAG_W-1:0] tag,
                                            input logic [31:0] val);
    return {src, tag, val};
  endfunction

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_tag = '0; alu_value = '0;
    lsb_valid = 1'b0; lsb_tag = '0; lsb_value = '0;
  endtask

  task automatic drive(input logic av, input logic [TAG_W-1:0] at, input logic [31:0] ad,
                       input logic lv, input logic [TAG_W-1:0] lt, input logic [31:0] ld);
    alu_valid = av; alu_tag = at; alu_value = ad;
    lsb_valid = lv; lsb_tag = lt; lsb_value = ld;
  endtask

  task automatic do_reset();
    rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
    idle();
    cyc();
    rst_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

  initial begin
    int ia, il, guard;
    logic a_ok, l_ok, saw_full;

    rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
    idle();
    cyc(); cyc();
    @(negedge clk_in);
    check("rst_cdb_valid", cdb_valid, 0);
    check("rst_cdb_tag", cdb_tag, 0);
    check("rst_cdb_value", cdb_value, 0);
    check("rst_cdb_src", cdb_src, 0);
    check("rst_alu_ready", alu_ready, 1);
    check("rst_lsb_ready", lsb_ready, 1);
    cyc();
    rst_in = 1'b0;

    // Single ALU result: two-edge latency, one cycle of valid.
    exp_q.push_back(ent(1'b0, 4'd3, 32'h1234_5678));
    drive(1'b1, 4'd3, 32'h1234_5678, 1'b0, '0, '0);
    cyc();
    idle();
    @(negedge clk_in);
    check("no_bypass", cdb_valid, 0);
    cyc();
    @(negedge clk_in);
    check("latency_valid", cdb_valid, 1);
    cyc();
    @(negedge clk_in);
    check("single_pulse", cdb_valid, 0);
    check("t1_drained", exp_q.size(), 0);

    // Both push six cycles: strict alternation starting with ALU.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(ent(1'b0, 4'(i), 32'hA000_0000 + 32'(i)));
      exp_q.push_back(ent(1'b1, 4'(8 + i), 32'hB000_0000 + 32'(i)));
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'(i), 32'hA000_0000 + 32'(i), 1'b1, 4'(8 + i), 32'hB000_0000 + 32'(i));
      cyc();
    end
    idle();
    repeat (14) cyc();
    check("t2_drained", exp_q.size(), 0);

    // Flood both with backpressure; LSB tags wrap 0-7 twice.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(ent(1'b0, 4'(i), 32'hA100_0000 + 32'(i)));
      exp_q.push_back(ent(1'b1, 4'(i % 8), 32'hB100_0000 + 32'(i)));
    end
    ia = 0; il = 0; guard = 0; saw_full = 1'b0;
    while ((ia < 16 || il < 16) && guard < 200) begin
      drive(ia < 16, 4'(ia), 32'hA100_0000 + 32'(ia), il < 16, 4'(il % 8), 32'hB100_0000 + 32'(il));
      @(negedge clk_in);
      a_ok = alu_valid && alu_ready;
      l_ok = lsb_valid && lsb_ready;
      if (!lsb_ready) saw_full = 1'b1;
      cyc();
      if (a_ok) ia++;
      if (l_ok) il++;
      guard++;
    end
    check("t3_bound", guard < 200, 1);
    idle();
    repeat (12) cyc();
    check("lsb_full_seen", saw_full, 1);
    check("t3_drained", exp_q.size(), 0);

    // Clear with a same-edge push; last_grant (ALU) survives the flush.
    do_reset();
    exp_q.push_back(ent(1'b0, 4'd0, 32'hC000_0000));
    exp_q.push_back(ent(1'b1, 4'd8, 32'hD000_0000));
    exp_q.push_back(ent(1'b0, 4'd1, 32'hC000_0001));
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(i), 32'hC000_0000 + 32'(i), 1'b1, 4'(8 + i), 32'hD000_0000 + 32'(i));
      cyc();
    end
    clear_in = 1'b1;
    drive(1'b1, 4'd4, 32'hC000_0004, 1'b0, '0, '0);
    cyc();
    clear_in = 1'b0;
    idle();
    @(negedge clk_in);
    check("clear_valid", cdb_valid, 0);
    check("clear_alu_ready", alu_ready, 1);
    check("clear_lsb_ready", lsb_ready, 1);
    repeat (4) cyc();
    check("t4_flushed", exp_q.size(), 0);
    exp_q.push_back(ent(1'b1, 4'd14, 32'hD000_0014));
    exp_q.push_back(ent(1'b0, 4'd6, 32'hC000_0006));
    drive(1'b1, 4'd6, 32'hC000_0006, 1'b1, 4'd14, 32'hD000_0014);
    cyc();
    idle();
    repeat (4) cyc();
    check("t4_drained", exp_q.size(), 0);

    // Pause while tag 5 is on the bus.
    do_reset();
    exp_q.push_back(ent(1'b0, 4'd5, 32'hE000_0005));
    exp_q.push_back(ent(1'b1, 4'd9, 32'hF000_0009));
    exp_q.push_back(ent(1'b0, 4'd6, 32'hE000_0006));
    drive(1'b1, 4'd5, 32'hE000_0005, 1'b1, 4'd9, 32'hF000_0009);
    cyc();
    drive(1'b1, 4'd6, 32'hE000_0006, 1'b0, '0, '0);
    cyc();
    rdy_in = 1'b0;
    drive(1'b1, 4'd7, 32'hE000_0007, 1'b1, 4'd7, 32'hF000_0007);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      check("pause_valid", cdb_valid, 1);
      check("pause_tag", cdb_tag, 5);
      check("pause_alu_ready", alu_ready, 0);
      check("pause_lsb_ready", lsb_ready, 0);
      cyc();
    end
    rdy_in = 1'b1;
    idle();
    repeat (5) cyc();
    check("t5_drained", exp_q.size(), 0);

    // Reset mid-stream after an ALU grant; next tie must go to ALU again.
    do_reset();
    exp_q.push_back(ent(1'b0, 4'd0, 32'h1100_0000));
    drive(1'b1, 4'd0, 32'h1100_0000, 1'b1, 4'd8, 32'h2200_0008);
    cyc();
    drive(1'b1, 4'd1, 32'h1100_0001, 1'b1, 4'd9, 32'h2200_0009);
    cyc();
    rst_in = 1'b1;
    idle();
    cyc();
    rst_in = 1'b0;
    @(negedge clk_in);
    check("mid_rst_valid", cdb_valid, 0);
    check("mid_rst_tag", cdb_tag, 0);
    check("mid_rst_value", cdb_value, 0);
    check("mid_rst_src", cdb_src, 0);
    check("mid_rst_alu_ready", alu_ready, 1);
    check("mid_rst_lsb_ready", lsb_ready, 1);
    cyc();
    exp_q.push_back(ent(1'b0, 4'd2, 32'h1100_0002));
    exp_q.push_back(ent(1'b1, 4'd10, 32'h2200_000A));
    drive(1'b1, 4'd2, 32'h1100_0002, 1'b1, 4'd10, 32'h2200_000A);
    cyc();
    idle();
    repeat (4) cyc();
    check("t6_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
